// File: rtl/pipe_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared pipeline constants: control-bundle layout, register-index
//           width and base opcodes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int CTRL_W    = 8;
  localparam int REG_IDX_W = 5;
  localparam int FUNCT_W   = 4;

  // Bundle layout {ALUsrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUop[1:0]}
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module  : hazard_detect
// Purpose : Combinational load-use hazard detector for the instruction in ID.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import pipe_pkg::*;
(
  input  logic                 ex_memread,
  input  logic                 ex_valid,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  output logic                 hazard
);

  // x0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign hazard = ex_memread & ex_valid & (ex_rd != '0) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module  : id_ex_stage
// Purpose : ID/EX pipeline register with load-use stall and flush bubbles.
//           Optional bubble counter enabled by macro ID_EX_STALL_CNT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
`ifdef ID_EX_STALL_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [FUNCT_W-1:0]   id_funct,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [XLEN-1:0]      id_pc,
  input  logic                 flush,
  output logic                 hazard_mux,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 ex_valid,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [FUNCT_W-1:0]   ex_funct,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [XLEN-1:0]      ex_pc
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_count
`endif
);

  logic w_hazard;
  logic w_stall;
  logic w_bubble;

  hazard_detect u_hazard_detect (
    .ex_memread (is_load(ex_ctrl)),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .hazard     (w_hazard)
  );

  // A flush overrides the stall so the branch redirect is never held off.
  assign w_stall    = w_hazard & ~flush;
  assign w_bubble   = w_stall | flush;
  assign hazard_mux = w_bubble;
  assign pc_write   = ~w_stall;
  assign ifid_write = ~w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl     <= '0;
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else begin
      // Operand fields load unconditionally; a bubble is marked only by
      // cleared control, valid and rd, which keeps the hazard path quiet.
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_funct    <= id_funct;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
      if (w_bubble) begin
        ex_ctrl  <= '0;
        ex_valid <= 1'b0;
        ex_rd    <= '0;
      end else begin
        ex_ctrl  <= id_ctrl;
        ex_valid <= 1'b1;
        ex_rd    <= id_rd;
      end
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Only load-use stalls are counted; flush bubbles are excluded.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (w_stall) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued when an
// ID instruction is presented and popped one clock later.
`default_nettype none

module tb_id_ex_stage;

  typedef struct {
    logic [7:0]  ctrl;
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_exp_t;

  localparam logic [7:0] CTRL_LW  = 8'hF0;
  localparam logic [7:0] CTRL_ADD = 8'h22;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        flush;
  logic        hazard_mux, pc_write, ifid_write;
  logic [7:0]  ex_ctrl;
  logic        ex_valid;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
`ifdef ID_EX_STALL_CNT_EN
  logic [1:0]  stall_count;
  logic [1:0]  exp_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  ex_exp_t sb_q[$];
  logic [31:0] pc_seq = 32'h0000_1000;

  always #5 clk = ~clk;

`ifdef ID_EX_STALL_CNT_EN
  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut (
`else
  id_ex_stage #(.XLEN(32)) dut (
`endif
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct(id_funct), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc), .flush(flush),
    .hazard_mux(hazard_mux), .pc_write(pc_write), .ifid_write(ifid_write),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_id(input logic [7:0] c, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] imm, input logic fl);
    id_ctrl     = c;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    id_imm      = imm;
    id_funct    = imm[3:0] ^ 4'h9;
    id_rs1_data = imm ^ 32'hA5A5_0000;
    id_rs2_data = imm ^ 32'h0000_5A5A;
    id_pc       = pc_seq;
    flush       = fl;
  endtask

  // Presents one ID instruction for one clock; exp_stall is the hazard the
  // scenario is constructed to produce.
  task automatic drive(input logic [7:0] c, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic fl,
                       input logic exp_stall);
    ex_exp_t e;
    ex_exp_t g;
    set_id(c, r1, r2, rd, imm, fl);
    @(negedge clk);
    chk("hazard_mux", {63'd0, hazard_mux}, {63'd0, exp_stall | fl});
    chk("pc_write",   {63'd0, pc_write},   {63'd0, ~exp_stall});
    chk("ifid_write", {63'd0, ifid_write}, {63'd0, ~exp_stall});
    e.valid = !(exp_stall || fl);
    e.ctrl  = e.valid ? c  : 8'h00;
    e.rd    = e.valid ? rd : 5'd0;
    e.rs1   = r1;
    e.rs2   = r2;
    e.funct = id_funct;
    e.rs1d  = id_rs1_data;
    e.rs2d  = id_rs2_data;
    e.imm   = imm;
    e.pc    = pc_seq;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (!exp_stall) pc_seq = pc_seq + 32'd4;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      g = sb_q.pop_front();
      chk("ex_valid", {63'd0, ex_valid}, {63'd0, g.valid});
      chk("ex_ctrl",  {56'd0, ex_ctrl},  {56'd0, g.ctrl});
      chk("ex_rd",    {59'd0, ex_rd},    {59'd0, g.rd});
      if (g.valid) begin
        chk("ex_rs1",      {59'd0, ex_rs1},      {59'd0, g.rs1});
        chk("ex_rs2",      {59'd0, ex_rs2},      {59'd0, g.rs2});
        chk("ex_funct",    {60'd0, ex_funct},    {60'd0, g.funct});
        chk("ex_rs1_data", {32'd0, ex_rs1_data}, {32'd0, g.rs1d});
        chk("ex_rs2_data", {32'd0, ex_rs2_data}, {32'd0, g.rs2d});
        chk("ex_imm",      {32'd0, ex_imm},      {32'd0, g.imm});
        chk("ex_pc",       {32'd0, ex_pc},       {32'd0, g.pc});
      end
    end
`ifdef ID_EX_STALL_CNT_EN
    if (exp_stall) exp_cnt = exp_cnt + 2'd1;
    chk("stall_count", {62'd0, stall_count}, {62'd0, exp_cnt});
`endif
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
`ifdef ID_EX_STALL_CNT_EN
    exp_cnt = 2'd0;
`endif
  endtask

  initial begin
    set_id(8'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    do_reset(2);

    // Reset state
    chk("rst_ex_ctrl",  {56'd0, ex_ctrl},  64'd0);
    chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ex_imm",   {32'd0, ex_imm},   64'd0);
    @(negedge clk);
    chk("rst_hazard_mux", {63'd0, hazard_mux}, 64'd0);
    chk("rst_pc_write",   {63'd0, pc_write},   64'd1);
    chk("rst_ifid_write", {63'd0, ifid_write}, 64'd1);
`ifdef ID_EX_STALL_CNT_EN
    chk("rst_stall_count", {62'd0, stall_count}, 64'd0);
`endif
    @(posedge clk); #1;

    // Plain pass-through
    drive(CTRL_ADD, 5'd1, 5'd2, 5'd5, 32'h10, 1'b0, 1'b0);
    // ALU op reading the register just written by a non-load: no stall
    drive(CTRL_ADD, 5'd5, 5'd5, 5'd9, 32'h44, 1'b0, 1'b0);

    // Load-use on rs1: one bubble, then the add advances
    drive(CTRL_LW,  5'd2, 5'd0, 5'd5, 32'h4, 1'b0, 1'b0);
    drive(CTRL_ADD, 5'd5, 5'd1, 5'd6, 32'h0, 1'b0, 1'b1);
    drive(CTRL_ADD, 5'd5, 5'd1, 5'd6, 32'h0, 1'b0, 1'b0);

    // Load-use on rs2
    drive(CTRL_LW,  5'd3, 5'd0, 5'd7, 32'h8, 1'b0, 1'b0);
    drive(CTRL_ADD, 5'd1, 5'd7, 5'd8, 32'h1, 1'b0, 1'b1);
    drive(CTRL_ADD, 5'd1, 5'd7, 5'd8, 32'h1, 1'b0, 1'b0);

    // Load to x0 never stalls
    drive(CTRL_LW,  5'd2, 5'd0, 5'd0, 32'hC, 1'b0, 1'b0);
    drive(CTRL_ADD, 5'd0, 5'd0, 5'd3, 32'h2, 1'b0, 1'b0);

    // Flush during a hazard: flush wins, PC not held, counter unchanged
    drive(CTRL_LW,  5'd2, 5'd0, 5'd5, 32'h14, 1'b0, 1'b0);
    drive(CTRL_ADD, 5'd5, 5'd1, 5'd6, 32'h3,  1'b1, 1'b0);
    // Flush without a hazard still squashes
    drive(CTRL_ADD, 5'd1, 5'd2, 5'd4, 32'h5,  1'b1, 1'b0);

    // Back-to-back loads each stall once
    drive(CTRL_LW,  5'd2, 5'd0, 5'd5, 32'h18, 1'b0, 1'b0);
    drive(CTRL_LW,  5'd5, 5'd0, 5'd6, 32'h1C, 1'b0, 1'b1);
    drive(CTRL_LW,  5'd5, 5'd0, 5'd6, 32'h1C, 1'b0, 1'b0);
    drive(CTRL_ADD, 5'd6, 5'd6, 5'd7, 32'h20, 1'b0, 1'b1);
    drive(CTRL_ADD, 5'd6, 5'd6, 5'd7, 32'h20, 1'b0, 1'b0);

    // Five load-use stalls from a clean start (2-bit counter wraps to 1)
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      drive(CTRL_LW,  5'd1, 5'd0, 5'(10 + i), 32'(32'h100 + i), 1'b0, 1'b0);
      drive(CTRL_ADD, 5'd2, 5'(10 + i), 5'd20, 32'(32'h200 + i), 1'b0, 1'b1);
      drive(CTRL_ADD, 5'd2, 5'(10 + i), 5'd20, 32'(32'h200 + i), 1'b0, 1'b0);
    end
`ifdef ID_EX_STALL_CNT_EN
    chk("stall_count_wrap", {62'd0, stall_count}, 64'd1);
`endif

    // Reset while a stall is pending discards it
    drive(CTRL_LW, 5'd2, 5'd0, 5'd5, 32'h30, 1'b0, 1'b0);
    set_id(CTRL_ADD, 5'd5, 5'd1, 5'd6, 32'h34, 1'b0);
    @(negedge clk);
    chk("pend_pc_write", {63'd0, pc_write}, 64'd0);
    do_reset(1);
    chk("mid_rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("mid_rst_ex_ctrl",  {56'd0, ex_ctrl},  64'd0);
`ifdef ID_EX_STALL_CNT_EN
    chk("mid_rst_stall_count", {62'd0, stall_count}, 64'd0);
`endif
    drive(CTRL_ADD, 5'd5, 5'd1, 5'd6, 32'h34, 1'b0, 1'b0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
